// File: rtl/gt_rst_seq.sv
// Reset sequencer for one GTX direction: drives PLL/GT resets, waits for lock and
// reset-done, qualifies ready, and retries on timeout or lock loss up to a bounded budget.
module gt_rst_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned DONE_TIMEOUT  = 65536,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned TIMER_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_in,
  input  logic       reset_done_in,
  output logic       pll_reset,
  output logic       gt_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_SETTLE    = 3'd3,
    S_READY     = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST   = TIMER_W'(DONE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_LAST  = 4'(MAX_RETRY - 1);
  localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRY);

  state_t             state;
  state_t             state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         retry_nxt;
  logic               do_retry;
  logic               flags_ok;

  assign flags_ok = pll_lock_in && reset_done_in;

  always_comb begin
    state_nxt = state;
    do_retry  = 1'b0;
    case (state)
      S_RST: begin
        if (timer == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (pll_lock_in)             state_nxt = S_WAIT_DONE;
        else if (timer == LOCK_LAST) do_retry  = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!pll_lock_in)            do_retry  = 1'b1;
        else if (reset_done_in)      state_nxt = S_SETTLE;
        else if (timer == DONE_LAST) do_retry  = 1'b1;
      end
      S_SETTLE: begin
        if (!flags_ok)                 do_retry  = 1'b1;
        else if (timer == SETTLE_LAST) state_nxt = S_READY;
      end
      S_READY: begin
        if (!flags_ok) do_retry = 1'b1;
      end
      S_FAIL:  state_nxt = S_FAIL;
      default: state_nxt = S_RST;
    endcase

    retry_nxt = retry_cnt;
    if (do_retry) begin
      if (retry_cnt == RETRY_LAST) begin
        state_nxt = S_FAIL;
        retry_nxt = RETRY_MAX;
      end else begin
        state_nxt = S_RST;
        retry_nxt = retry_cnt + 4'd1;
      end
    end else if (state_nxt == S_READY && state != S_READY) begin
      retry_nxt = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state
  // register and never glitch onto the GT reset pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RST;
      timer     <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      gt_reset  <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      state_out <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= (state_nxt != state) ? '0 : timer + TIMER_W'(1);
      retry_cnt <= retry_nxt;
      pll_reset <= (state_nxt == S_RST) || (state_nxt == S_FAIL);
      gt_reset  <= (state_nxt == S_RST) || (state_nxt == S_WAIT_LOCK) || (state_nxt == S_FAIL);
      ready     <= (state_nxt == S_READY);
      fail      <= (state_nxt == S_FAIL);
      state_out <= state_nxt;
    end
  end

endmodule

// File: tb/tb_gt_rst_seq.sv
// Bench for gt_rst_seq: directed bring-up/retry scenarios plus randomized flag
// activity, all checked cycle by cycle against a phase/age reference model.
module tb_gt_rst_seq;

  localparam int RST_C    = 4;
  localparam int LOCK_TO  = 16;
  localparam int DONE_TO  = 16;
  localparam int SETTLE_C = 8;
  localparam int MAXR     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       done = 1'b0;
  logic       pll_reset, gt_reset, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  gt_rst_seq #(
    .RST_CYCLES(RST_C),
    .LOCK_TIMEOUT(LOCK_TO),
    .DONE_TIMEOUT(DONE_TO),
    .SETTLE_CYCLES(SETTLE_C),
    .MAX_RETRY(MAXR),
    .TIMER_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock_in(lock),
    .reset_done_in(done),
    .pll_reset(pll_reset),
    .gt_reset(gt_reset),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state_out(state_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: current phase (numbered as the debug encoding), the edge at
  // which the phase's first cycle began, and the failed-attempt count.
  int m_phase = 0;
  int m_start = 0;
  int m_retry = 0;
  int edge_n  = 0;

  task automatic enter(input int p);
    m_phase = p;
    m_start = edge_n + 1;
  endtask

  task automatic fail_attempt();
    if (m_retry + 1 == MAXR) begin
      m_retry = MAXR;
      enter(5);
    end else begin
      m_retry = m_retry + 1;
      enter(0);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input bit d);
    int age;
    age = edge_n - m_start;
    if (r) begin
      m_retry = 0;
      enter(0);
    end else begin
      case (m_phase)
        0: if (age == RST_C - 1) enter(1);
        1: if (l) enter(2); else if (age == LOCK_TO - 1) fail_attempt();
        2: if (!l) fail_attempt(); else if (d) enter(3); else if (age == DONE_TO - 1) fail_attempt();
        3: if (!(l && d)) fail_attempt(); else if (age == SETTLE_C - 1) begin enter(4); m_retry = 0; end
        4: if (!(l && d)) fail_attempt();
        default: ;
      endcase
    end
    edge_n++;
  endtask

  function automatic logic [10:0] model_outs();
    logic p, g, rd, f;
    p  = (m_phase == 0) || (m_phase == 5);
    g  = (m_phase == 0) || (m_phase == 1) || (m_phase == 5);
    rd = (m_phase == 4);
    f  = (m_phase == 5);
    return {p, g, rd, f, 4'(m_retry), 3'(m_phase)};
  endfunction

  // One clock: apply inputs for the current cycle, let the edge happen, compare.
  task automatic step(input bit r, input bit l, input bit d);
    rst  = r;
    lock = l;
    done = d;
    @(posedge clk);
    model_edge(r, l, d);
    #1;
    check("outs", {21'd0, pll_reset, gt_reset, ready, fail, retry_cnt, state_out}, {21'd0, model_outs()});
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1);
    check("rst_vals", {21'd0, pll_reset, gt_reset, ready, fail, retry_cnt, state_out}, 32'b110_0000_0000);
    cyc = 0;
  endtask

  task automatic bringup(input string tag);
    int t_pll, t_gt, t_rdy;
    logic [3:0] rc;
    t_pll = -1; t_gt = -1; t_rdy = -1; rc = 4'hf;
    for (int i = 0; i < 40; i++) begin
      if (t_pll < 0 && !pll_reset) t_pll = cyc;
      if (t_gt < 0 && !gt_reset) t_gt = cyc;
      if (ready) begin t_rdy = cyc; rc = retry_cnt; break; end
      step(1'b0, 1'b1, 1'b1);
    end
    check({tag, "_pll_fall"}, t_pll, 4);
    check({tag, "_gt_fall"}, t_gt, 5);
    check({tag, "_ready_cyc"}, t_rdy, 14);
    check({tag, "_ready_retry"}, rc, 0);
  endtask

  initial begin
    int t_fail, r0, r1, r2;
    logic [3:0] rc, rc20, rc40, rc17, rc2;
    logic st_ok, rdy16, rdy17;
    logic [2:0] st17, st20, st21;
    bit rl, rd, rr;

    // 1: nominal bring-up
    step(1'b1, 1'b1, 1'b1);
    do_reset();
    bringup("s1");

    // 2: lock never arrives
    do_reset();
    t_fail = -1; rc20 = 4'hf; rc40 = 4'hf;
    for (int i = 0; i < 100; i++) begin
      if (cyc == 20) rc20 = retry_cnt;
      if (cyc == 40) rc40 = retry_cnt;
      if (fail) begin t_fail = cyc; break; end
      step(1'b0, 1'b0, 1'b0);
    end
    check("s2_fail_cyc", t_fail, 60);
    check("s2_retry20", rc20, 1);
    check("s2_retry40", rc40, 2);
    check("s2_fail_outs", {28'd0, pll_reset, gt_reset, retry_cnt[1:0]}, 32'b1111);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    check("s2_sticky", {28'd0, fail, state_out}, 32'b1101);

    // 6a: one-cycle reset out of S_FAIL, then normal restart
    do_reset();
    bringup("s6_fail");

    // 3: reset_done pulses low for 3 cycles mid-settle
    do_reset();
    while (cyc < 9) step(1'b0, 1'b1, 1'b1);
    check("s3_in_settle", state_out, 3);
    r0 = -1; r1 = -1; rc = 4'hf;
    for (int i = 0; i < 40; i++) begin
      if (r0 < 0 && state_out == 3'd0) begin r0 = cyc; rc = retry_cnt; end
      if (ready) begin r1 = cyc; break; end
      step(1'b0, 1'b1, !(cyc >= 9 && cyc <= 11));
    end
    check("s3_rst_cyc", r0, 10);
    check("s3_retry", rc, 1);
    check("s3_ready_delta", r1 - r0, 14);

    // 4: lock drops for one cycle while ready
    do_reset();
    r2 = -1; rc2 = 4'hf; rc17 = 4'hf; st17 = 3'd7; rdy16 = 1'b0; rdy17 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (cyc == 16) rdy16 = ready;
      if (cyc == 17) begin rdy17 = ready; st17 = state_out; rc17 = retry_cnt; end
      if (cyc > 17 && ready) begin r2 = cyc; rc2 = retry_cnt; break; end
      step(1'b0, cyc != 16, 1'b1);
    end
    check("s4_ready_before", rdy16, 1);
    check("s4_ready_drop", rdy17, 0);
    check("s4_state_drop", st17, 0);
    check("s4_retry_drop", rc17, 1);
    check("s4_ready_again", r2, 31);
    check("s4_retry_clear", rc2, 0);

    // 5: reset_done arrives on the last wait-done cycle
    do_reset();
    st20 = 3'd7; st21 = 3'd7; rc = 4'hf;
    for (int i = 0; i < 30; i++) begin
      if (cyc == 20) st20 = state_out;
      if (cyc == 21) begin st21 = state_out; rc = retry_cnt; break; end
      step(1'b0, 1'b1, cyc >= 20);
    end
    check("s5_wait_done", st20, 2);
    check("s5_settle", st21, 3);
    check("s5_no_retry", rc, 0);

    // 6b: one-cycle reset out of S_SETTLE
    do_reset();
    while (cyc < 8) step(1'b0, 1'b1, 1'b1);
    st_ok = (state_out == 3'd3);
    check("s6_in_settle", st_ok, 1);
    do_reset();
    bringup("s6_settle");

    // Randomized flag activity with occasional resets
    do_reset();
    rl = 1'b1; rd = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) rl = ~rl;
      if ($urandom_range(0, 29) == 0) rd = ~rd;
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rl, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
